// File: rtl/hram_arbiter_pkg.sv
// Shared types and constants for the two-port HyperRAM burst arbiter.
// Watchdog constants exist only when HRAM_ARB_WDOG_EN is defined.
package hram_arb_pkg;
    localparam int NUM_PORTS        = 2;
    localparam int ADDR_W           = 12;
    localparam int LEN_W            = 5;
    localparam int DATA_W           = 16;
    localparam int MAX_RD_LEN_DEF   = 8;
    localparam int MAX_WR_LEN_DEF   = 30;
    localparam int GUARD_CYCLES_DEF = 16;
`ifdef HRAM_ARB_WDOG_EN
    localparam int WDOG_W           = 10;
    localparam int WDOG_CYCLES_DEF  = 1023;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

    // Zero-length requests still move one word; oversize requests clamp to the controller cap.
    function automatic logic [LEN_W-1:0] eff_len(input logic             rd,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] cap_rd,
                                                 input logic [LEN_W-1:0] cap_wr);
        logic [LEN_W-1:0] cap;
        cap = rd ? cap_rd : cap_wr;
        if (len == '0) begin
            return LEN_W'(1);
        end
        if (len > cap) begin
            return cap;
        end
        return len;
    endfunction
endpackage

// File: rtl/hram_arbiter_if.sv
// Requester and hyperram_ctrl-facing signals of the burst arbiter.
// slave = arbiter view, master = requesters plus controller view.
interface hram_arbiter_if;
    import hram_arb_pkg::*;

    logic [NUM_PORTS-1:0]        cmd_valid;
    logic [NUM_PORTS-1:0]        cmd_ready;
    logic [NUM_PORTS-1:0]        cmd_rd;
    logic [NUM_PORTS*ADDR_W-1:0] cmd_addr;
    logic [NUM_PORTS*LEN_W-1:0]  cmd_len;
    logic [NUM_PORTS*DATA_W-1:0] wr_data;
    logic [NUM_PORTS-1:0]        wr_ready;
    logic [NUM_PORTS-1:0]        rd_vld;
    logic [DATA_W-1:0]           rd_data;
    logic [NUM_PORTS-1:0]        err;
    logic                        sram_req;
    logic                        sram_rd;
    logic [ADDR_W-1:0]           sram_addr;
    logic [DATA_W-1:0]           sram_wr_data;
    logic                        sram_ready;
    logic                        sram_rd_data_vld;
    logic [DATA_W-1:0]           sram_rd_data;

    modport slave (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_len, wr_data,
               sram_ready, sram_rd_data_vld, sram_rd_data,
        output cmd_ready, wr_ready, rd_vld, rd_data, err,
               sram_req, sram_rd, sram_addr, sram_wr_data
    );

    modport master (
        output cmd_valid, cmd_rd, cmd_addr, cmd_len, wr_data,
               sram_ready, sram_rd_data_vld, sram_rd_data,
        input  cmd_ready, wr_ready, rd_vld, rd_data, err,
               sram_req, sram_rd, sram_addr, sram_wr_data
    );
endinterface

// File: rtl/hram_rr_arbiter.sv
// Two-way round-robin grant; the pointer moves past the granted port on accept.
module hram_rr_arbiter
    import hram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_accept,
    output logic [NUM_PORTS-1:0] o_gnt_oh,
    output logic                 o_gnt_idx
);
    logic r_ptr;

    // Pointer only matters on a tie; a lone requester always wins.
    assign o_gnt_idx = (i_req[0] && i_req[1]) ? r_ptr : i_req[1];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_oh
        assign o_gnt_oh[gi] = i_req[gi] && (o_gnt_idx == 1'(gi));
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_gnt_idx;
        end
    end
endmodule

// File: rtl/hram_arbiter.sv
// Shares the hyperram_ctrl sram_* port between two burst requesters with a guard gap.
// Optional beat watchdog: define HRAM_ARB_WDOG_EN.
module hram_arbiter
    import hram_arb_pkg::*;
#(
    parameter int MAX_RD_LEN   = MAX_RD_LEN_DEF,
    parameter int MAX_WR_LEN   = MAX_WR_LEN_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
`ifdef HRAM_ARB_WDOG_EN
    ,
    parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
`endif
) (
    input  logic          clk,
    input  logic          reset_,
    hram_arbiter_if.slave bus
);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    arb_state_t           r_state, w_state_next;
    logic [NUM_PORTS-1:0] r_cmd_ready, w_cmd_ready_next;
    logic                 r_gnt_idx, w_gnt_idx_next;
    logic                 r_rd, w_rd_next;
    logic                 r_sram_req, w_sram_req_next;
    logic                 r_sram_rd, w_sram_rd_next;
    logic [ADDR_W-1:0]    r_addr, w_addr_next;
    logic [LEN_W-1:0]     r_len, w_len_next;
    logic [LEN_W-1:0]     r_count, w_count_next;
    logic [GUARD_W-1:0]   r_guard, w_guard_next;

    logic [NUM_PORTS-1:0] w_arb_gnt_oh;
    logic                 w_arb_gnt_idx;
    logic                 w_accept;
    logic                 w_req_rd;
    logic [ADDR_W-1:0]    w_req_addr;
    logic [LEN_W-1:0]     w_req_len;
    logic                 w_beat;
`ifdef HRAM_ARB_WDOG_EN
    logic [WDOG_W-1:0]    r_wdog, w_wdog_next;
    logic [NUM_PORTS-1:0] r_err, w_err_next;
`endif

    // No new accept while the previous accept pulse is still out.
    assign w_accept = (r_state == ST_IDLE) && !(|r_cmd_ready) && (|bus.cmd_valid);

    hram_rr_arbiter u_rr (
        .clk       (clk),
        .reset_    (reset_),
        .i_req     (bus.cmd_valid),
        .i_accept  (w_accept),
        .o_gnt_oh  (w_arb_gnt_oh),
        .o_gnt_idx (w_arb_gnt_idx)
    );

    assign w_req_rd   = bus.cmd_rd[w_arb_gnt_idx];
    assign w_req_addr = w_arb_gnt_idx ? bus.cmd_addr[2*ADDR_W-1:ADDR_W] : bus.cmd_addr[ADDR_W-1:0];
    assign w_req_len  = w_arb_gnt_idx ? bus.cmd_len[2*LEN_W-1:LEN_W]    : bus.cmd_len[LEN_W-1:0];

    // Overrun beats and anything outside BURST fall out here and are never forwarded.
    assign w_beat = (r_state == ST_BURST) && (r_count < r_len) &&
                    (r_rd ? bus.sram_rd_data_vld : bus.sram_ready);

    always_comb begin
        w_state_next     = r_state;
        w_cmd_ready_next = '0;
        w_gnt_idx_next   = r_gnt_idx;
        w_rd_next        = r_rd;
        w_addr_next      = r_addr;
        w_len_next       = r_len;
        w_count_next     = r_count;
        w_guard_next     = r_guard;
        w_sram_req_next  = r_sram_req;
        w_sram_rd_next   = r_sram_rd;
`ifdef HRAM_ARB_WDOG_EN
        w_wdog_next      = r_wdog;
        w_err_next       = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|r_cmd_ready) begin
                    w_state_next    = ST_BURST;
                    w_sram_req_next = !r_rd;
                    w_sram_rd_next  = r_rd;
                    w_count_next    = '0;
`ifdef HRAM_ARB_WDOG_EN
                    w_wdog_next     = '0;
`endif
                end else if (w_accept) begin
                    w_cmd_ready_next = w_arb_gnt_oh;
                    w_gnt_idx_next   = w_arb_gnt_idx;
                    w_rd_next        = w_req_rd;
                    w_addr_next      = w_req_addr;
                    w_len_next       = eff_len(w_req_rd, w_req_len,
                                               LEN_W'(MAX_RD_LEN), LEN_W'(MAX_WR_LEN));
                end
            end
            ST_BURST: begin
                if (w_beat) begin
                    w_count_next = r_count + 1'b1;
                end
`ifdef HRAM_ARB_WDOG_EN
                w_wdog_next = w_beat ? '0 : r_wdog + 1'b1;
`endif
                if (w_beat && (r_count + 1'b1 == r_len)) begin
                    w_state_next    = ST_GUARD;
                    w_sram_req_next = 1'b0;
                    w_sram_rd_next  = 1'b0;
                    w_guard_next    = '0;
                end
`ifdef HRAM_ARB_WDOG_EN
                else if (!w_beat && (r_wdog == WDOG_W'(WDOG_CYCLES - 1))) begin
                    w_err_next[r_gnt_idx] = 1'b1;
                    w_state_next          = ST_GUARD;
                    w_sram_req_next       = 1'b0;
                    w_sram_rd_next        = 1'b0;
                    w_guard_next          = '0;
                end
`endif
            end
            ST_GUARD: begin
                if (r_guard == GUARD_W'(GUARD_CYCLES - 1)) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_guard_next = r_guard + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= '0;
            r_gnt_idx   <= 1'b0;
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_guard     <= '0;
            r_sram_req  <= 1'b0;
            r_sram_rd   <= 1'b0;
`ifdef HRAM_ARB_WDOG_EN
            r_wdog      <= '0;
            r_err       <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_gnt_idx   <= w_gnt_idx_next;
            r_rd        <= w_rd_next;
            r_addr      <= w_addr_next;
            r_len       <= w_len_next;
            r_count     <= w_count_next;
            r_guard     <= w_guard_next;
            r_sram_req  <= w_sram_req_next;
            r_sram_rd   <= w_sram_rd_next;
`ifdef HRAM_ARB_WDOG_EN
            r_wdog      <= w_wdog_next;
            r_err       <= w_err_next;
`endif
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign bus.wr_ready[gi] = w_beat && !r_rd && (r_gnt_idx == 1'(gi));
        assign bus.rd_vld[gi]   = w_beat &&  r_rd && (r_gnt_idx == 1'(gi));
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.sram_req     = r_sram_req;
    assign bus.sram_rd      = r_sram_rd;
    assign bus.sram_addr    = r_addr;
    assign bus.sram_wr_data = r_gnt_idx ? bus.wr_data[2*DATA_W-1:DATA_W] : bus.wr_data[DATA_W-1:0];
    assign bus.rd_data      = bus.sram_rd_data;
`ifdef HRAM_ARB_WDOG_EN
    assign bus.err = r_err;
`else
    assign bus.err = '0;
`endif
endmodule

// File: tb/tb_hram_arbiter.sv
// Directed bench for hram_arbiter: vector table of single bursts plus hand sequences
// for arbitration order, guard gap, async reset and the optional watchdog.
module tb_hram_arbiter;
    localparam int GUARD = 16;

    logic clk    = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    hram_arbiter_if bus();

    hram_arbiter #(
        .MAX_RD_LEN   (8),
        .MAX_WR_LEN   (30),
        .GUARD_CYCLES (GUARD)
`ifdef HRAM_ARB_WDOG_EN
        ,
        .WDOG_CYCLES  (20)
`endif
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    typedef struct {
        int port;
        bit rd;
        int addr;
        int len;
        int exp_beats;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;
    int s_wr[2];
    int s_rd[2];
    int s_reqw, s_reqr, s_both, s_data_err, s_addr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic issue(input int port, input bit rd, input int addr, input int len);
        bus.cmd_valid[port]          = 1'b1;
        bus.cmd_rd[port]             = rd;
        bus.cmd_addr[port*12 +: 12]  = addr[11:0];
        bus.cmd_len[port*5 +: 5]     = len[4:0];
    endtask

    task automatic wait_ready(input int max_cyc, output logic [1:0] got, output int cyc);
        got = 2'b00;
        cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #2;
            if (bus.cmd_ready != 2'b00) begin
                got = bus.cmd_ready;
                cyc = c;
                break;
            end
        end
    endtask

    // Controller model: beat every cycle while a request is up, plus 'tail' overrun beats after it drops.
    task automatic serve(input int tail);
        int tl;
        bit started, act, beat_on;
        logic [15:0] pat;
        tl = tail; started = 0;
        s_wr[0] = 0; s_wr[1] = 0; s_rd[0] = 0; s_rd[1] = 0;
        s_reqw = 0; s_reqr = 0; s_both = 0; s_data_err = 0; s_addr = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            act = bus.sram_req || bus.sram_rd;
            if (act) begin
                if (!started) s_addr = int'(bus.sram_addr);
                started = 1;
                if (bus.sram_req) s_reqw++;
                if (bus.sram_rd)  s_reqr++;
                if (bus.sram_req && bus.sram_rd) s_both++;
                beat_on = 1;
            end else if (started && tl > 0) begin
                beat_on = 1;
                tl--;
            end else begin
                beat_on = 0;
            end
            pat = 16'h5A00 + 16'(c);
            bus.sram_ready       = beat_on;
            bus.sram_rd_data_vld = beat_on;
            bus.sram_rd_data     = pat;
            #1;
            for (int p = 0; p < 2; p++) begin
                if (bus.wr_ready[p]) begin
                    s_wr[p]++;
                    if (bus.sram_wr_data != ((p == 1) ? 16'hB0B1 : 16'hA0A1)) s_data_err++;
                end
                if (bus.rd_vld[p]) s_rd[p]++;
            end
            if (bus.rd_data != pat) s_data_err++;
            if (!beat_on && (started || c >= 3)) break;
        end
        bus.sram_ready       = 1'b0;
        bus.sram_rd_data_vld = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        logic [1:0] got;
        int cyc, p, o;
        p = vecs[idx].port;
        o = 1 - p;
        issue(p, vecs[idx].rd, vecs[idx].addr, vecs[idx].len);
        wait_ready(60, got, cyc);
        check($sformatf("v%0d_ready", idx), int'(got), 1 << p);
        bus.cmd_valid[p] = 1'b0;
        serve(3);
        check($sformatf("v%0d_wr_beats", idx), s_wr[p], vecs[idx].rd ? 0 : vecs[idx].exp_beats);
        check($sformatf("v%0d_rd_beats", idx), s_rd[p], vecs[idx].rd ? vecs[idx].exp_beats : 0);
        check($sformatf("v%0d_other_port", idx), s_wr[o] + s_rd[o], 0);
        check($sformatf("v%0d_req_cycles", idx), vecs[idx].rd ? s_reqr : s_reqw, vecs[idx].exp_beats);
        check($sformatf("v%0d_wrong_req", idx), (vecs[idx].rd ? s_reqw : s_reqr) + s_both, 0);
        check($sformatf("v%0d_addr", idx), s_addr, vecs[idx].addr);
        check($sformatf("v%0d_data", idx), s_data_err, 0);
        $display("txn v%0d: port=%0d rd=%0d addr=0x%03h len=%0d beats=%0d", idx, p,
                 vecs[idx].rd, vecs[idx].addr, vecs[idx].len, vecs[idx].rd ? s_rd[p] : s_wr[p]);
    endtask

    initial begin
        logic [1:0] got;
        int cyc, n, beats, cnt;
        logic [1:0] errv;

        vecs[0] = '{port: 0, rd: 1'b0, addr: 'h010, len: 4,  exp_beats: 4};
        vecs[1] = '{port: 1, rd: 1'b1, addr: 'h123, len: 20, exp_beats: 8};
        vecs[2] = '{port: 0, rd: 1'b0, addr: 'hFFF, len: 0,  exp_beats: 1};
        vecs[3] = '{port: 1, rd: 1'b0, addr: 'h555, len: 31, exp_beats: 30};
        vecs[4] = '{port: 0, rd: 1'b1, addr: 'h0AA, len: 8,  exp_beats: 8};
        vecs[5] = '{port: 1, rd: 1'b0, addr: 'h2F0, len: 30, exp_beats: 30};
        vecs[6] = '{port: 0, rd: 1'b1, addr: 'h001, len: 1,  exp_beats: 1};

        bus.cmd_valid = '0; bus.cmd_rd = '0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = 32'hB0B1_A0A1;
        bus.sram_ready = 1'b0; bus.sram_rd_data_vld = 1'b0; bus.sram_rd_data = '0;

        // Reset state
        #12;
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_wr_ready",  int'(bus.wr_ready), 0);
        check("rst_rd_vld",    int'(bus.rd_vld), 0);
        check("rst_err",       int'(bus.err), 0);
        check("rst_sram_req",  int'(bus.sram_req), 0);
        check("rst_sram_rd",   int'(bus.sram_rd), 0);
        check("rst_sram_addr", int'(bus.sram_addr), 0);
        #10 reset_ = 1'b1;
        @(posedge clk); #2;
        check("idle_no_req", int'({bus.sram_req, bus.sram_rd, bus.cmd_ready}), 0);

        // Simultaneous requests after reset: port 0, then port 1, then port 0 again
        issue(0, 1'b0, 'h0A0, 2);
        issue(1, 1'b1, 'h0B0, 3);
        wait_ready(10, got, cyc);
        check("both_first_grant", int'(got), 1);
        check("accept_latency", cyc, 1);
        bus.cmd_valid[0] = 1'b0;
        serve(2);
        check("both_p0_wr_beats", s_wr[0], 2);
        check("both_p0_addr", s_addr, 'h0A0);
        wait_ready(60, got, cyc);
        check("both_second_grant", int'(got), 2);
        bus.cmd_valid[1] = 1'b0;
        serve(2);
        check("both_p1_rd_beats", s_rd[1], 3);
        check("both_p1_addr", s_addr, 'h0B0);
        $display("txn both: p0 write len2 then p1 read len3");
        issue(0, 1'b0, 'h0C0, 1);
        issue(1, 1'b0, 'h0D0, 1);
        wait_ready(60, got, cyc);
        check("both_third_grant", int'(got), 1);
        bus.cmd_valid = 2'b00;
        serve(0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back from port 0 with guard gap
        issue(0, 1'b0, 'h200, 1);
        wait_ready(60, got, cyc);
        check("b2b_first_grant", int'(got), 1);
        issue(0, 1'b0, 'h201, 2);
        serve(0);
        check("b2b_first_beats", s_wr[0], 1);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #2;
            if (bus.cmd_ready[0]) begin n = c; break; end
        end
        check("b2b_guard_gap", n, GUARD + 1);
        bus.cmd_valid[0] = 1'b0;
        serve(0);
        check("b2b_second_beats", s_wr[0], 2);
        check("b2b_second_addr", s_addr, 'h201);
        $display("txn b2b: port0 two writes, gap=%0d", n);

        // Async reset during beat 2 of a 6-word read; pointer was moved to port 1 by this grant
        issue(0, 1'b1, 'h300, 6);
        wait_ready(60, got, cyc);
        check("rstmid_grant", int'(got), 1);
        bus.cmd_valid[0] = 1'b0;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.sram_rd_data_vld = bus.sram_rd;
            #1;
            if (bus.rd_vld[0]) beats++;
            if (beats == 2) break;
        end
        check("rstmid_beats_before", beats, 2);
        reset_ = 1'b0;
        #1;
        check("rstmid_cmd_ready", int'(bus.cmd_ready), 0);
        check("rstmid_rd_vld",    int'(bus.rd_vld), 0);
        check("rstmid_wr_ready",  int'(bus.wr_ready), 0);
        check("rstmid_err",       int'(bus.err), 0);
        check("rstmid_req_rd",    int'({bus.sram_req, bus.sram_rd}), 0);
        check("rstmid_addr",      int'(bus.sram_addr), 0);
        bus.sram_rd_data_vld = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_ = 1'b1;
        issue(0, 1'b0, 'h310, 1);
        issue(1, 1'b0, 'h320, 1);
        wait_ready(10, got, cyc);
        check("rstmid_ptr_port0", int'(got), 1);
        bus.cmd_valid = 2'b00;
        serve(0);
        $display("txn rstmid: reset after 2 beats, regrant=%0d", got);

        // Stalled burst: watchdog abort or indefinite wait
        issue(1, 1'b0, 'h3C0, 5);
        wait_ready(60, got, cyc);
        check("stall_grant", int'(got), 2);
        bus.cmd_valid[1] = 1'b0;
`ifdef HRAM_ARB_WDOG_EN
        n = 0; errv = 2'b00;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #2;
            if (bus.err != 2'b00) begin n = c; errv = bus.err; break; end
        end
        check("wdog_cycle", n, 21);
        check("wdog_err_port", int'(errv), 2);
        check("wdog_req_drop", int'(bus.sram_req), 0);
        @(posedge clk); #2;
        check("wdog_err_pulse", int'(bus.err), 0);
        repeat (GUARD + 2) @(posedge clk);
        $display("txn wdog: err after %0d cycles", n);
`else
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (bus.sram_req && bus.err == 2'b00) cnt++;
        end
        check("stall_req_held", cnt, 40);
        serve(0);
        check("stall_finish_beats", s_wr[1], 5);
        $display("txn stall: request held %0d cycles, then 5 beats", cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
